// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding shared with the ALU and the sequencer FSM states.
package alu_pkg;
    localparam logic [1:0] OFF   = 2'd0;
    localparam logic [1:0] ADD   = 2'd1;
    localparam logic [1:0] SUB   = 2'd2;
    localparam logic [1:0] NO_OP = 2'd3;

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO with wrap-bit pointers and full/empty flags.
module alu_cmd_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;

    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + (AW+1)'(1);
            if (pop && !empty) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands, issues them one at a time and
// presents each captured result over a valid/ready handshake.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_flag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_flag,
    output logic [1:0]       res_op,
    output logic [7:0]       res_cnt
);
    localparam int EW = 2*WIDTH + 2;

    state_t           state;
    logic             full, empty, pop;
    logic [EW-1:0]    head;
    logic [WIDTH-1:0] head_a, head_b;
    logic [1:0]       head_op, cur_op;

    assign cmd_ready = !full;
    assign {head_a, head_b, head_op} = head;
    assign pop = !empty && (state == IDLE || (state == HOLD && res_ready));

    alu_cmd_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .pop   (pop),
        .wdata ({cmd_a, cmd_b, cmd_op}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // cur_op remembers the real opcode, since NO_OP is issued to the ALU as OFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= OFF;
            cur_op    <= OFF;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_flag  <= 1'b0;
            res_op    <= OFF;
            res_cnt   <= '0;
        end else begin
            case (state)
                DRIVE: begin
                    res_valid <= 1'b1;
                    res_op    <= cur_op;
                    alu_op    <= OFF;
                    state     <= HOLD;
                    if (cur_op != NO_OP) begin
                        res_data <= cur_op == OFF ? '0 : alu_out;
                        res_flag <= cur_op == OFF ? 1'b0 : alu_flag;
                    end
                end
                IDLE, HOLD: begin
                    if (state == HOLD && res_ready) begin
                        res_valid <= 1'b0;
                        res_cnt   <= res_cnt + 8'd1;
                    end
                    if (pop) begin
                        alu_a  <= head_a;
                        alu_b  <= head_b;
                        alu_op <= head_op == NO_OP ? OFF : head_op;
                        cur_op <= head_op;
                        state  <= DRIVE;
                    end else if (state == HOLD && res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed table, multi-cycle corner cases and randomized
// traffic checked against a queue-based result model.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_ready;
    logic [WIDTH-1:0] cmd_a, cmd_b;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [1:0]       alu_op;
    logic             alu_flag;
    logic             res_valid, res_ready, res_flag;
    logic [WIDTH-1:0] res_data;
    logic [1:0]       res_op;
    logic [7:0]       res_cnt;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_flag  (alu_flag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_flag  (res_flag),
        .res_op    (res_op),
        .res_cnt   (res_cnt)
    );

    // Combinational ALU attached to the issue bus.
    always_comb begin
        alu_out  = '0;
        alu_flag = 1'b0;
        if (alu_op == ADD) begin
            {alu_flag, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
        end else if (alu_op == SUB) begin
            alu_out  = alu_a >= alu_b ? alu_a - alu_b : alu_b - alu_a;
            alu_flag = alu_b > alu_a;
        end
    end

    typedef struct {int data; int flag; int op;} res_t;
    typedef struct {logic [3:0] a; logic [3:0] b; logic [1:0] op; int data; int flag;} vec_t;

    int         checks = 0;
    int         errors = 0;
    res_t       exp_q[$];
    int         last_data, last_flag;
    logic [7:0] tb_cnt;
    bit         pushed, snap_ok;
    logic [3:0] s_data;
    logic       s_flag;
    logic [1:0] s_op;
    vec_t       vecs[9];
    int         n, first, second;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Results come out in command order, so NO_OP repeats the previous command's result.
    function automatic res_t predict(int a, int b, int op);
        res_t r;
        r.op = op;
        case (op)
            0: begin r.data = 0; r.flag = 0; end
            1: begin r.data = (a + b) % (1 << WIDTH); r.flag = (a + b) >= (1 << WIDTH); end
            2: begin r.data = a > b ? a - b : b - a; r.flag = b > a; end
            default: begin r.data = last_data; r.flag = last_flag; end
        endcase
        last_data = r.data;
        last_flag = r.flag;
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        last_data = 0;
        last_flag = 0;
        tb_cnt    = '0;
        snap_ok   = 1'b0;
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_flag"}, res_flag, 0);
        chk({tag, "_res_op"}, res_op, 0);
        chk({tag, "_res_cnt"}, res_cnt, 0);
    endtask

    // Called at a negedge with inputs already set: records the handshakes that
    // the coming posedge will perform, then advances to the next negedge.
    task automatic cycle();
        res_t e;
        pushed = cmd_valid && cmd_ready;
        if (pushed) exp_q.push_back(predict(int'(cmd_a), int'(cmd_b), int'(cmd_op)));
        chk("alu_op_never_noop", alu_op == NO_OP, 0);
        if (snap_ok) begin
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, s_data);
            chk("hold_flag", res_flag, s_flag);
            chk("hold_op", res_op, s_op);
        end
        snap_ok = res_valid && !res_ready;
        s_data  = res_data;
        s_flag  = res_flag;
        s_op    = res_op;
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("res_data", res_data, e.data);
                chk("res_flag", res_flag, e.flag);
                chk("res_op", res_op, e.op);
            end
            chk("res_cnt", res_cnt, tb_cnt);
            tb_cnt = tb_cnt + 8'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{4'd7,  4'd9,  ADD,   0,  1};
        vecs[1] = '{4'd3,  4'd5,  SUB,   2,  1};
        vecs[2] = '{4'd5,  4'd3,  SUB,   2,  0};
        vecs[3] = '{4'd2,  4'd3,  ADD,   5,  0};
        vecs[4] = '{4'd1,  4'd1,  NO_OP, 5,  0};
        vecs[5] = '{4'd6,  4'd4,  OFF,   0,  0};
        vecs[6] = '{4'd15, 4'd15, ADD,   14, 1};
        vecs[7] = '{4'd8,  4'd2,  NO_OP, 14, 1};
        vecs[8] = '{4'd9,  4'd9,  SUB,   0,  0};

        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = OFF; res_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1 check_reset_values("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle();
        check_reset_values("idle");

        // One command at a time: latency and captured value per opcode.
        for (int i = 0; i < 9; i++) begin
            cmd_valid = 1'b1; cmd_a = vecs[i].a; cmd_b = vecs[i].b; cmd_op = vecs[i].op;
            res_ready = 1'b0;
            cycle();
            cmd_valid = 1'b0;
            chk($sformatf("vec%0d_valid_n1", i), res_valid, 0);
            cycle();
            chk($sformatf("vec%0d_valid_n2", i), res_valid, 0);
            cycle();
            chk($sformatf("vec%0d_valid_n3", i), res_valid, 1);
            chk($sformatf("vec%0d_data", i), res_data, vecs[i].data);
            chk($sformatf("vec%0d_flag", i), res_flag, vecs[i].flag);
            chk($sformatf("vec%0d_op", i), res_op, vecs[i].op);
            res_ready = 1'b1;
            cycle();
            res_ready = 1'b0;
            chk($sformatf("vec%0d_cnt", i), res_cnt, i + 1);
        end

        // Back-to-back results two cycles apart.
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_a = 4'd3; cmd_b = 4'd5; cmd_op = SUB;
        cycle();
        cmd_a = 4'd5; cmd_b = 4'd3;
        cycle();
        cmd_valid = 1'b0;
        first = -1; second = -1;
        for (int i = 0; i < 10; i++) begin
            if (res_valid) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            cycle();
        end
        chk("b2b_first", first, 1);
        chk("b2b_gap", second - first, 2);

        // Backpressure: one in flight plus DEPTH buffered, then drain in order.
        res_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cmd_valid = 1'b1; cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 2'($urandom);
            cycle();
            if (pushed) n++;
        end
        chk("bp_accepted", n, DEPTH + 1);
        chk("bp_ready_low", cmd_ready, 0);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        cycle();
        chk("bp_ready_after_pop", cmd_ready, 1);
        for (int i = 0; i < 40 && (exp_q.size() > 0 || res_valid); i++) cycle();
        chk("bp_drained", exp_q.size(), 0);

        // Reset while DRIVE with three commands queued.
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = ADD;
            cycle();
        end
        cmd_a = 4'd4; cmd_b = 4'd4; res_ready = 1'b1;
        cycle();
        chk("pre_reset_drive", res_valid, 0);
        cmd_valid = 1'b0; res_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        repeat (10) cycle();
        chk("post_reset_quiet", res_valid, 0);

        // Randomized traffic, long enough for res_cnt to wrap.
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = ($urandom % 4) != 0;
            cmd_a     = 4'($urandom);
            cmd_b     = 4'($urandom);
            cmd_op    = 2'($urandom);
            res_ready = ($urandom % 10) < 7;
            cycle();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() > 0 || res_valid); i++) cycle();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_idle", res_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
